// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
package mole_game_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StOver  = 2'd3
   } game_state_e;

   localparam int unsigned LifeW = 4;
   localparam int unsigned LfsrW = 16;
   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [LfsrW-1:0] LfsrPoly = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Seeded 16-bit Galois LFSR with enable; exposes the low OutW bits.
module lfsr16
   import mole_game_pkg::*;
#(
   parameter logic [LfsrW-1:0] Seed = 16'hACE1,
   parameter int unsigned      OutW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   output logic [OutW-1:0] value
);

   logic [LfsrW-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrPoly : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= Seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q[OutW-1:0];

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole engine: game FSM, countdown, mole spawn/expiry, hit scoring
// and high score. All outputs are registered.
module mole_game_core
   import mole_game_pkg::*;
#(
   parameter int unsigned N_HOLES    = 8,
   parameter int unsigned MAX_MOLES  = 4,
   parameter int unsigned LIFE_TICKS = 3,
   parameter int unsigned GAME_SECS  = 30,
   parameter int unsigned SCORE_W    = 8,
   parameter bit          PENALTY    = 1'b1,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_1hz,
   input  logic               tick_spawn,
   input  logic               btn_start,
   input  logic               btn_pause,
   input  logic [N_HOLES-1:0] sw,
   output logic [N_HOLES-1:0] mole_map,
   output logic [6:0]         sec_left,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic [SCORE_W-1:0] miss_cnt,
   output logic [1:0]         game_state,
   output logic               game_over
);

   localparam int ScoreMax = (1 << SCORE_W) - 1;

   game_state_e                       state_q, state_d;
   logic [N_HOLES-1:0]                map_q, map_d;
   logic [N_HOLES-1:0][LifeW-1:0]     life_q, life_d;
   logic [6:0]                        sec_q, sec_d;
   logic [SCORE_W-1:0]                score_q, score_d;
   logic [SCORE_W-1:0]                high_q, high_d;
   logic [SCORE_W-1:0]                miss_q, miss_d;
   logic                              over_q, over_d;
   logic [N_HOLES-1:0]                sw_q;
   logic [3:0]                        lfsr_nib;

   lfsr16 #(
      .Seed (LFSR_SEED),
      .OutW (4)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .value (lfsr_nib)
   );

   logic [N_HOLES-1:0] edges, hit_mask, pen_mask, live_mask;
   logic [N_HOLES-1:0] spawn_lo, spawn_hi, spawn_mask;
   int unsigned        n_hit, n_pen, n_exp, n_live, cand;
   int                 score_sum, miss_sum;

   always_comb begin
      state_d    = state_q;
      map_d      = map_q;
      life_d     = life_q;
      sec_d      = sec_q;
      score_d    = score_q;
      miss_d     = miss_q;
      high_d     = high_q;
      over_d     = 1'b0;
      edges      = sw & ~sw_q;
      hit_mask   = '0;
      pen_mask   = '0;
      live_mask  = '0;
      spawn_lo   = '0;
      spawn_hi   = '0;
      spawn_mask = '0;
      n_hit      = 0;
      n_pen      = 0;
      n_exp      = 0;
      n_live     = 0;
      cand       = 0;
      score_sum  = 0;
      miss_sum   = 0;

      unique case (state_q)
         StIdle, StOver: begin
            if (btn_start) begin
               state_d = StRun;
               sec_d   = 7'(GAME_SECS);
               score_d = '0;
               miss_d  = '0;
               map_d   = '0;
               life_d  = '0;
            end
         end
         StPause: begin
            if (btn_pause) state_d = StRun;
         end
         StRun: begin
            // Hits are judged against the map as it stood before this cycle.
            hit_mask = edges & map_q;
            if (PENALTY) pen_mask = edges & ~map_q;
            live_mask = map_q & ~hit_mask;
            for (int i = 0; i < int'(N_HOLES); i++) begin
               if (hit_mask[i]) begin
                  life_d[i] = '0;
                  n_hit++;
               end
               if (pen_mask[i]) n_pen++;
            end

            if (tick_spawn) begin
               for (int i = 0; i < int'(N_HOLES); i++) begin
                  if (live_mask[i]) begin
                     life_d[i] = life_q[i] - LifeW'(1);
                     if (life_q[i] == LifeW'(1)) begin
                        live_mask[i] = 1'b0;
                        n_exp++;
                     end
                  end
               end
               for (int i = 0; i < int'(N_HOLES); i++) begin
                  if (live_mask[i]) n_live++;
               end
               if (n_live < MAX_MOLES) begin
                  cand = 32'(lfsr_nib) % N_HOLES;
                  // Lowest free hole at/after cand, else lowest free overall: a wrapping probe.
                  for (int i = int'(N_HOLES) - 1; i >= 0; i--) begin
                     if (!live_mask[i]) begin
                        spawn_lo    = '0;
                        spawn_lo[i] = 1'b1;
                        if (i >= int'(cand)) begin
                           spawn_hi    = '0;
                           spawn_hi[i] = 1'b1;
                        end
                     end
                  end
                  spawn_mask = (spawn_hi != '0) ? spawn_hi : spawn_lo;
               end
               for (int i = 0; i < int'(N_HOLES); i++) begin
                  if (spawn_mask[i]) life_d[i] = LifeW'(LIFE_TICKS);
               end
               live_mask = live_mask | spawn_mask;
            end
            map_d = live_mask;

            score_sum = int'(score_q) + int'(n_hit) - int'(n_pen);
            if (score_sum < 0) begin
               score_d = '0;
            end else if (score_sum > ScoreMax) begin
               score_d = SCORE_W'(ScoreMax);
            end else begin
               score_d = SCORE_W'(score_sum);
            end
            miss_sum = int'(miss_q) + int'(n_exp);
            miss_d   = (miss_sum > ScoreMax) ? SCORE_W'(ScoreMax) : SCORE_W'(miss_sum);

            if (tick_1hz) begin
               sec_d = sec_q - 7'd1;
               if (sec_q == 7'd1) begin
                  state_d = StOver;
                  over_d  = 1'b1;
                  map_d   = '0;
                  life_d  = '0;
                  if (score_d > high_q) high_d = score_d;
               end
            end
            if (btn_pause && state_d == StRun) state_d = StPause;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         map_q   <= '0;
         life_q  <= '0;
         sec_q   <= 7'(GAME_SECS);
         score_q <= '0;
         high_q  <= '0;
         miss_q  <= '0;
         over_q  <= 1'b0;
         sw_q    <= '0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         life_q  <= life_d;
         sec_q   <= sec_d;
         score_q <= score_d;
         high_q  <= high_d;
         miss_q  <= miss_d;
         over_q  <= over_d;
         sw_q    <= sw;
      end
   end

   assign mole_map   = map_q;
   assign sec_left   = sec_q;
   assign score      = score_q;
   assign high_score = high_q;
   assign miss_cnt   = miss_q;
   assign game_state = state_q;
   assign game_over  = over_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Randomised and directed bench for mole_game_core against a per-cycle
// behavioural model built from the game rules.
module tb_mole_game_core;

   localparam int N    = 8;
   localparam int MAXM = 4;
   localparam int LIFE = 3;
   localparam int SECS = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick_1hz = 1'b0, tick_spawn = 1'b0, btn_start = 1'b0, btn_pause = 1'b0;
   logic [N-1:0] sw = '0;
   logic [N-1:0] mole_map;
   logic [6:0]   sec_left;
   logic [7:0]   score, high_score, miss_cnt;
   logic [1:0]   game_state;
   logic         game_over;

   int total = 0;
   int bad   = 0;

   // Model state: m_life[i] > 0 means a mole sits in hole i.
   int          m_state, m_sec, m_score, m_high, m_miss;
   bit          m_over;
   int          m_life[N];
   logic [N-1:0] m_swp;
   logic [15:0] m_lfsr;

   mole_game_core #(
      .N_HOLES    (N),
      .MAX_MOLES  (MAXM),
      .LIFE_TICKS (LIFE),
      .GAME_SECS  (SECS),
      .SCORE_W    (8),
      .PENALTY    (1'b1),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_1hz   (tick_1hz),
      .tick_spawn (tick_spawn),
      .btn_start  (btn_start),
      .btn_pause  (btn_pause),
      .sw         (sw),
      .mole_map   (mole_map),
      .sec_left   (sec_left),
      .score      (score),
      .high_score (high_score),
      .miss_cnt   (miss_cnt),
      .game_state (game_state),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic [15:0] taps;
      taps = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));  // x^16, x^14, x^13, x^11
      return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
   endfunction

   function automatic logic [N-1:0] m_map();
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i] = (m_life[i] > 0);
      return r;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_sec   = SECS;
      m_score = 0;
      m_high  = 0;
      m_miss  = 0;
      m_over  = 0;
      foreach (m_life[i]) m_life[i] = 0;
      m_swp   = '0;
      m_lfsr  = 16'hACE1;
   endtask

   task automatic model_step();
      int hits = 0, pens = 0, nexp = 0, live = 0, cand = 0;
      bit found = 0;
      m_over = 0;
      case (m_state)
         0, 3: begin
            if (btn_start) begin
               m_state = 1;
               m_sec   = SECS;
               m_score = 0;
               m_miss  = 0;
               foreach (m_life[i]) m_life[i] = 0;
            end
         end
         2: if (btn_pause) m_state = 1;
         default: begin
            for (int i = 0; i < N; i++) begin
               if (sw[i] && !m_swp[i]) begin
                  if (m_life[i] > 0) begin
                     hits++;
                     m_life[i] = 0;
                  end else begin
                     pens++;
                  end
               end
            end
            if (tick_spawn) begin
               for (int i = 0; i < N; i++) begin
                  if (m_life[i] > 0) begin
                     m_life[i]--;
                     if (m_life[i] == 0) nexp++;
                  end
               end
               for (int i = 0; i < N; i++) if (m_life[i] > 0) live++;
               if (live < MAXM) begin
                  cand = int'(m_lfsr[3:0]) % N;
                  for (int k = 0; k < N; k++) begin
                     if (!found && m_life[(cand + k) % N] == 0) begin
                        m_life[(cand + k) % N] = LIFE;
                        found = 1;
                     end
                  end
               end
            end
            m_score = m_score + hits - pens;
            if (m_score < 0) m_score = 0;
            if (m_score > 255) m_score = 255;
            m_miss = m_miss + nexp;
            if (m_miss > 255) m_miss = 255;
            if (tick_1hz) begin
               m_sec--;
               if (m_sec == 0) begin
                  m_state = 3;
                  m_over  = 1;
                  foreach (m_life[i]) m_life[i] = 0;
                  if (m_score > m_high) m_high = m_score;
               end
            end
            if (m_state == 1 && btn_pause) m_state = 2;
         end
      endcase
      m_swp  = sw;
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic check_outputs();
      check("state", game_state, m_state);
      check("map", mole_map, m_map());
      check("sec", sec_left, m_sec);
      check("score", score, m_score);
      check("high", high_score, m_high);
      check("miss", miss_cnt, m_miss);
      check("over", game_over, m_over);
      check("max_moles", $countones(mole_map) <= MAXM, 1);
   endtask

   task automatic run(input bit t1, input bit ts, input bit bs, input bit bp,
                      input logic [N-1:0] s);
      tick_1hz   = t1;
      tick_spawn = ts;
      btn_start  = bs;
      btn_pause  = bp;
      sw         = s;
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic score_points(input int n);
      for (int k = 0; k < n; k++) begin
         int h;
         h = -1;
         if (m_map() == '0) run(0, 1, 0, 0, '0);
         check("find_mole", m_map() != '0, 1);
         for (int i = 0; i < N; i++) if (m_life[i] > 0 && h < 0) h = i;
         if (h >= 0) begin
            run(0, 0, 0, 0, N'(1) << h);
            run(0, 0, 0, 0, '0);
         end
      end
   endtask

   task automatic end_game();
      for (int g = 0; g < SECS && m_state == 1; g++) run(1, 0, 0, 0, '0);
   endtask

   initial begin
      int h, sv_sec, sv_score;
      logic [N-1:0] sv_map;
      model_reset();
      #12;
      check("rst_state", game_state, 0);
      check("rst_map", mole_map, 0);
      check("rst_sec", sec_left, SECS);
      check("rst_score", score, 0);
      check("rst_high", high_score, 0);
      check("rst_miss", miss_cnt, 0);
      check("rst_over", game_over, 0);
      rst_n = 1'b1;

      // Countdown to game over.
      run(0, 0, 1, 0, '0);
      check("start_state", game_state, 1);
      check("start_sec", sec_left, SECS);
      for (int s = SECS - 1; s >= 0; s--) begin
         run(0, 0, 0, 0, '0);
         run(1, 0, 0, 0, '0);
         check("cd_sec", sec_left, s);
         check("cd_over", game_over, s == 0);
      end
      run(0, 0, 0, 0, '0);
      check("over_pulse", game_over, 0);
      check("over_state", game_state, 3);
      check("over_map", mole_map, 0);

      // Hit, then penalties saturating at zero.
      run(0, 0, 1, 0, '0);
      score_points(1);
      check("hit_score", score, 1);
      h = 0;
      for (int i = N - 1; i >= 0; i--) if (m_life[i] == 0) h = i;
      run(0, 0, 0, 0, N'(1) << h);
      run(0, 0, 0, 0, '0);
      check("pen_score", score, 0);
      run(0, 0, 0, 0, N'(1) << h);
      run(0, 0, 0, 0, '0);
      check("pen_sat", score, 0);
      end_game();

      // Hit lands in the same cycle the mole would expire.
      run(0, 0, 1, 0, '0);
      run(0, 1, 0, 0, '0);
      h = 0;
      for (int i = N - 1; i >= 0; i--) if (m_life[i] > 0) h = i;
      run(0, 1, 0, 0, '0);
      run(0, 1, 0, 0, '0);
      run(0, 1, 0, 0, N'(1) << h);
      check("hx_score", score, 1);
      check("hx_miss", miss_cnt, 0);
      end_game();

      // Pause freezes the game; no phantom edge on resume.
      run(0, 0, 1, 0, '0);
      run(0, 1, 0, 0, '0);
      run(0, 1, 0, 0, '0);
      run(1, 0, 0, 0, '0);
      run(0, 0, 0, 1, '0);
      check("pause_state", game_state, 2);
      sv_map   = m_map();
      sv_sec   = m_sec;
      sv_score = m_score;
      repeat (3) run(1, 0, 0, 0, '0);
      repeat (2) run(0, 1, 0, 0, '0);
      run(0, 0, 0, 0, N'(1));
      run(0, 0, 0, 0, N'(1));
      check("pause_sec", sec_left, sv_sec);
      check("pause_map", mole_map, sv_map);
      check("pause_score", score, sv_score);
      run(0, 0, 0, 1, N'(1));
      check("resume_state", game_state, 1);
      run(0, 0, 0, 0, N'(1));
      check("resume_score", score, sv_score);
      run(1, 0, 0, 0, N'(1));
      check("resume_sec", sec_left, sv_sec - 1);
      end_game();

      // High score keeps the best of two games.
      run(0, 0, 1, 0, '0);
      score_points(7);
      end_game();
      check("g1_score", score, 7);
      run(0, 0, 1, 0, '0);
      score_points(3);
      end_game();
      check("g2_score", score, 3);
      check("g2_high", high_score, 7);

      // Random play.
      for (int c = 0; c < 2500; c++) begin
         logic [N-1:0] s;
         s = sw;
         for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) s[i] = ~s[i];
         run($urandom_range(11) == 0, $urandom_range(3) == 0, $urandom_range(39) == 0,
             $urandom_range(49) == 0, s);
      end

      // Asynchronous reset in the middle of a game.
      if (m_state == 2) run(0, 0, 0, 1, '0);
      else if (m_state != 1) run(0, 0, 1, 0, '0);
      run(0, 1, 0, 0, '0);
      run(0, 1, 0, 0, '0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_state", game_state, 0);
      check("arst_map", mole_map, 0);
      check("arst_sec", sec_left, SECS);
      check("arst_score", score, 0);
      check("arst_high", high_score, 0);
      check("arst_miss", miss_cnt, 0);
      check("arst_over", game_over, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run(0, 0, 1, 0, '0);
      run(0, 1, 0, 0, '0);
      run(1, 0, 0, 0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
